// File: rtl/shift_unit_iter.sv
// Iterative shifter/rotator: one bit position per clock, Amt clocks per request.
// Ports: clk, rst (async low), A/B/Sel operand, Op, Amt, Start -> Shift_OUT, Carry_OUT, Busy, Done.
module shift_unit_iter #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Sel,
  input  logic [2:0]            Op,
  input  logic [AMT_WIDTH-1:0]  Amt,
  input  logic                  Start,
  output logic [DATA_WIDTH-1:0] Shift_OUT,
  output logic                  Carry_OUT,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [2:0]            op_q, op_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
  logic                  carry_out_q, carry_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  op_valid;
  logic [DATA_WIDTH-1:0] step_work;
  logic                  step_carry;
  logic                  lsb, msb;

  assign op_valid = (Op <= OP_ROL);
  assign lsb      = work_q[0];
  assign msb      = work_q[DATA_WIDTH-1];

  // One-bit step of the captured operation on the work register.
  always_comb begin
    step_work  = work_q;
    step_carry = carry_q;
    case (op_q)
      OP_SRL: begin
        step_work  = {1'b0, work_q[DATA_WIDTH-1:1]};
        step_carry = lsb;
      end
      OP_SLL: begin
        step_work  = {work_q[DATA_WIDTH-2:0], 1'b0};
        step_carry = msb;
      end
      OP_SRA: begin
        step_work  = {msb, work_q[DATA_WIDTH-1:1]};
        step_carry = lsb;
      end
      OP_ROR: begin
        step_work  = {lsb, work_q[DATA_WIDTH-1:1]};
        step_carry = lsb;
      end
      OP_ROL: begin
        step_work  = {work_q[DATA_WIDTH-2:0], msb};
        step_carry = msb;
      end
      default: begin
        step_work  = work_q;
        step_carry = carry_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    op_d        = op_q;
    carry_d     = carry_q;
    shift_out_d = shift_out_q;
    carry_out_d = carry_out_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          work_d  = Sel ? B : A;
          op_d    = Op;
          carry_d = 1'b0;
          if (op_valid && Amt != '0) begin
            cnt_d   = Amt;
            state_d = SHIFT;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        work_d  = step_work;
        carry_d = step_carry;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == AMT_WIDTH'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Results are published on the same edge that enters DONE.
    if (state_d == DONE) begin
      shift_out_d = work_d;
      carry_out_d = carry_d;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      shift_out_q <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      shift_out_q <= shift_out_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Shift_OUT = shift_out_q;
  assign Carry_OUT = carry_out_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Bench for shift_unit_iter: directed cases plus random requests vs arithmetic model.
// Drives/samples 1 time unit after each rising edge.
module tb_shift_unit_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic        Sel;
  logic [2:0]  Op;
  logic [3:0]  Amt;
  logic        Start;
  logic [15:0] Shift_OUT;
  logic        Carry_OUT;
  logic        Busy;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_res;
  logic        prev_c;

  shift_unit_iter #(
    .DATA_WIDTH(16),
    .AMT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .Op       (Op),
    .Amt      (Amt),
    .Start    (Start),
    .Shift_OUT(Shift_OUT),
    .Carry_OUT(Carry_OUT),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic [15:0] x, input logic [2:0] op,
                                input int n, output logic [15:0] r,
                                output logic c);
    r = x;
    c = 1'b0;
    if (op <= 3'd4 && n != 0) begin
      case (op)
        3'd0: begin r = x >> n; c = x[n-1]; end
        3'd1: begin r = x << n; c = x[16-n]; end
        3'd2: begin r = 16'($signed(x) >>> n); c = x[n-1]; end
        3'd3: begin r = (x >> n) | (x << (16 - n)); c = x[n-1]; end
        default: begin r = (x << n) | (x >> (16 - n)); c = x[16-n]; end
      endcase
    end
  endfunction

  task automatic junk(input logic st);
    A     = 16'($urandom);
    B     = 16'($urandom);
    Sel   = 1'($urandom);
    Op    = 3'($urandom);
    Amt   = 4'($urandom);
    Start = st;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic do_req(input logic [15:0] a, input logic [15:0] b,
                        input logic sel, input logic [2:0] op,
                        input logic [3:0] amt, input bit noisy);
    logic [15:0] er;
    logic        ec;
    int          n;
    model(sel ? b : a, op, int'(amt), er, ec);
    n = (op <= 3'd4) ? int'(amt) : 0;
    A = a; B = b; Sel = sel; Op = op; Amt = amt; Start = 1'b1;
    @(posedge clk); #1;
    junk(1'b0);
    for (int k = 0; k <= n; k++) begin
      check("busy", 32'(Busy), 32'd1);
      check("done", 32'(Done), 32'(k == n));
      if (k == n) begin
        check("result", 32'(Shift_OUT), 32'(er));
        check("carry", 32'(Carry_OUT), 32'(ec));
      end else begin
        check("hold_res", 32'(Shift_OUT), 32'(prev_res));
        check("hold_c", 32'(Carry_OUT), 32'(prev_c));
      end
      junk(noisy ? 1'($urandom) : 1'b0);
      if (k == n) Start = 1'b1;
      @(posedge clk); #1;
    end
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_done", 32'(Done), 32'd0);
    check("idle_res", 32'(Shift_OUT), 32'(er));
    check("idle_c", 32'(Carry_OUT), 32'(ec));
    Start    = 1'b0;
    prev_res = er;
    prev_c   = ec;
  endtask

  initial begin
    rst = 1'b0;
    junk(1'b0);
    prev_res = '0;
    prev_c   = 1'b0;
    #12;
    check("rst_res", 32'(Shift_OUT), 32'd0);
    check("rst_c", 32'(Carry_OUT), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    do_req(16'h8001, 16'h0000, 1'b0, 3'b000, 4'd1, 1'b0);
    do_req(16'h1234, 16'h8000, 1'b1, 3'b010, 4'd4, 1'b0);
    do_req(16'h00FF, 16'h0000, 1'b0, 3'b001, 4'd12, 1'b0);
    do_req(16'h8001, 16'h0000, 1'b0, 3'b100, 4'd15, 1'b0);
    do_req(16'hA5C3, 16'h0000, 1'b0, 3'b011, 4'd0, 1'b0);
    do_req(16'h0000, 16'h5A3C, 1'b1, 3'b111, 4'd5, 1'b0);
    do_req(16'hB00D, 16'h0000, 1'b0, 3'b011, 4'd7, 1'b1);

    for (int i = 0; i < 60; i++)
      do_req(16'($urandom), 16'($urandom), 1'($urandom),
             3'($urandom_range(0, 5)), 4'($urandom), 1'b1);

    // Abort mid-shift with an asynchronous reset.
    A = 16'hFFFF; Sel = 1'b0; Op = 3'b000; Amt = 4'd10; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_busy", 32'(Busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_res", 32'(Shift_OUT), 32'd0);
    check("abort_c", 32'(Carry_OUT), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", 32'(Done), 32'd0);
    end
    rst = 1'b1;
    prev_res = '0;
    prev_c   = 1'b0;
    do_req(16'h0F0F, 16'h0000, 1'b0, 3'b100, 4'd3, 1'b0);
    do_req(16'h0000, 16'hC001, 1'b1, 3'b000, 4'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_unit_iter.md
SHIFT_UNIT_ITER -- requirements
Module: shift_unit_iter

Parameters
REQ-001 SHALL have DATA_WIDTH, default 16: operand/result width, >= 2.
REQ-002 SHALL have AMT_WIDTH, default 4: shift-amount width, equal to clog2(DATA_WIDTH).

Interface
REQ-003 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have A  input  DATA_WIDTH  operand 0.
REQ-006 SHALL have B  input  DATA_WIDTH  operand 1.
REQ-007 SHALL have Sel  input  1  operand select: 0 = A, 1 = B.
REQ-008 SHALL have Op  input  3  operation: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL; 101-111 invalid.
REQ-009 SHALL have Amt  input  AMT_WIDTH  shift count, 0..DATA_WIDTH-1.
REQ-010 SHALL have Start  input  1  request; sampled only in IDLE.
REQ-011 SHALL have Shift_OUT  output  DATA_WIDTH  registered result.
REQ-012 SHALL have Carry_OUT  output  1  registered last bit shifted or rotated out.
REQ-013 SHALL have Busy  output  1  high while state != IDLE.
REQ-014 SHALL have Done  output  1  one-cycle result-valid pulse.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 In IDLE with Start=1 and valid Op, the edge SHALL capture the operand selected by Sel into the work register, Op into an op register, and Amt into the counter.
  - Next state: SHIFT if Amt != 0; DONE if Amt == 0.
REQ-017 In IDLE with Start=1 and invalid Op, the edge SHALL capture the operand unchanged, clear the internal carry, and go to DONE.
REQ-018 A, B, Sel, Op and Amt SHALL be ignored after capture; later changes do not affect the running operation.
REQ-019 In SHIFT, each edge SHALL perform exactly one 1-bit operation on the work register and decrement the counter.
  - Internal carry <= the bit leaving the word (SRL/SRA/ROR: bit 0; SLL/ROL: MSB).
  - SRL fills the MSB with 0; SLL fills bit 0 with 0; SRA replicates the MSB; ROR/ROL wrap the leaving bit to the opposite end.
REQ-020 The SHIFT edge where the counter equals 1 SHALL move to DONE; SHIFT SHALL last exactly Amt cycles.
REQ-021 The edge entering DONE SHALL load Shift_OUT from the work result and Carry_OUT from the internal carry.
  - Amt == 0 or invalid Op: Carry_OUT = 0 and Shift_OUT = captured operand.
REQ-022 Done SHALL be high for exactly the one cycle spent in DONE, i.e. after edge E0+Amt, where E0 is the edge that accepted Start.
REQ-023 From DONE the FSM SHALL return to IDLE unconditionally.
REQ-024 Start SHALL be ignored while Busy=1, including in the DONE cycle; it is not queued.
REQ-025 Back-to-back requests: a new Start SHALL be accepted on the first edge after DONE.
REQ-026 Shift_OUT and Carry_OUT SHALL hold their values until the next entry to DONE.
REQ-027 Busy SHALL be high for Amt+1 cycles per accepted request (1 cycle for Amt=0 or invalid Op).

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, counter 0, work register 0, internal carry 0, Shift_OUT 0, Carry_OUT 0, Busy 0, Done 0.
REQ-029 Reset during SHIFT or DONE SHALL abort the operation with no Done pulse.
REQ-030 After rst releases, the first Start SHALL be accepted on the first rising edge.

Verification (DATA_WIDTH=16)
REQ-031 A=16'h8001, Sel=0, Op=SRL, Amt=1, Start -> Done after E1; Shift_OUT=16'h4000; Carry_OUT=1.
REQ-032 B=16'h8000, Sel=1, Op=SRA, Amt=4 -> Busy high 5 cycles; Done after E4; Shift_OUT=16'hF800; Carry_OUT=0.
REQ-033 A=16'h00FF, Op=SLL, Amt=12 -> Shift_OUT=16'hF000, Carry_OUT=1; A=16'h8001, Op=ROL, Amt=15 -> Shift_OUT=16'hC000, Carry_OUT=0.
REQ-034 Amt=0 with Op=ROR, then a separate request with Op=3'b111 and Amt=5 -> each gives Done after E0, Shift_OUT=operand, Carry_OUT=0.
REQ-035 Start re-pulsed with new operands during SHIFT -> ignored; result matches the first request.
REQ-036 rst=0 asserted mid-SHIFT -> all outputs 0 immediately, no Done; a new request after release completes normally.
